// File: rtl/psum_accum_sfp_pkg.sv
// Shared types and helpers for the psum accumulate / SFP stage.
package psum_accum_sfp_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int unsigned PSUM_BW_DEF = 16;
    localparam int unsigned COL_DEF     = 8;

    // Bit offset of lane 'lane' inside a packed psum_bw*col vector.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned bw);
        return lane * bw;
    endfunction

    // Signed saturation limits for a lane of width bw.
    function automatic longint psum_max(input int unsigned bw);
        return (longint'(1) <<< (bw - 1)) - 1;
    endfunction

    function automatic longint psum_min(input int unsigned bw);
        return -(longint'(1) <<< (bw - 1));
    endfunction

    localparam longint PSUM_MAX = psum_max(PSUM_BW_DEF);
    localparam longint PSUM_MIN = psum_min(PSUM_BW_DEF);

endpackage

// File: rtl/psum_accum_sfp_if.sv
// Input psum stream and output pixel stream of the accumulate / SFP stage.
interface psum_accum_sfp_if #(
    parameter int unsigned psum_bw = 16,
    parameter int unsigned col     = 8
);
    logic [psum_bw*col-1:0] psum_in;
    logic                   in_valid;
    logic                   in_ready;
    logic [psum_bw*col-1:0] sfp_out;
    logic                   out_valid;
    logic                   out_ready;

    // Producer of psums / consumer of pixels.
    modport master (
        output psum_in, in_valid, out_ready,
        input  in_ready, sfp_out, out_valid
    );

    // The accumulate stage itself.
    modport slave (
        input  psum_in, in_valid, out_ready,
        output in_ready, sfp_out, out_valid
    );
endinterface

// File: rtl/psum_accum_sfp_lane_acc.sv
// One lane: saturating accumulator plus ReLU select into the output register.
module psum_lane_acc
    import psum_accum_sfp_pkg::*;
#(
    parameter int unsigned psum_bw = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [psum_bw-1:0] din,
    input  logic               load,
    input  logic               clear,
    input  logic               finish,
    input  logic               relu_en,
    output logic [psum_bw-1:0] dout
);

    localparam logic signed [psum_bw:0] SAT_HI = (psum_bw+1)'(psum_max(psum_bw));
    localparam logic signed [psum_bw:0] SAT_LO = (psum_bw+1)'(psum_min(psum_bw));

    logic signed [psum_bw-1:0] acc;
    logic signed [psum_bw:0]   wide;
    logic signed [psum_bw-1:0] sum;

    // Add one bit wide, then clamp back into the lane range.
    always_comb begin
        wide = $signed({acc[psum_bw-1], acc}) + $signed({din[psum_bw-1], din});
        if (wide > SAT_HI) begin
            sum = SAT_HI[psum_bw-1:0];
        end else if (wide < SAT_LO) begin
            sum = SAT_LO[psum_bw-1:0];
        end else begin
            sum = wide[psum_bw-1:0];
        end
    end

    // Accumulator update and result capture on the final tap.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc  <= '0;
            dout <= '0;
        end else begin
            if (clear || finish) begin
                acc <= '0;
            end else if (load) begin
                acc <= sum;
            end
            if (finish) begin
                dout <= (relu_en && sum[psum_bw-1]) ? '0 : sum;
            end
        end
    end

endmodule

// File: rtl/psum_accum_sfp.sv
// Accumulates NTAP psum vectors per pixel, applies optional ReLU and hands
// the pixel downstream over a valid/ready handshake.
module psum_accum_sfp
    import psum_accum_sfp_pkg::*;
#(
    parameter int unsigned psum_bw = 16,
    parameter int unsigned col     = 8,
    parameter int unsigned NTAP    = 9,
    parameter int unsigned PIX_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    psum_accum_sfp_if.slave  bus,
    input  logic             relu_en,
    input  logic             flush,
    output logic [PIX_W-1:0] pix_cnt,
    output logic             busy
);

    localparam int unsigned TAP_W = (NTAP > 1) ? $clog2(NTAP) : 1;
    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(NTAP - 1);

    state_t           state;
    logic [TAP_W-1:0] tap_cnt;
    logic             out_valid_q;
    logic             accept;
    logic             last_tap;
    logic             lane_load;
    logic             lane_clear;
    logic             lane_finish;

    // Flush wins over a simultaneous beat, so it is folded into accept.
    always_comb begin
        accept      = (state == ACC) && bus.in_valid && !flush;
        last_tap    = (tap_cnt == TAP_LAST);
        lane_load   = accept && !last_tap;
        lane_finish = accept && last_tap;
        lane_clear  = (state == ACC) && flush;
    end

    assign bus.in_ready  = (state == ACC);
    assign bus.out_valid = out_valid_q;
    assign busy          = (tap_cnt != '0) || out_valid_q;

    for (genvar i = 0; i < col; i++) begin : g_lane
        psum_lane_acc #(
            .psum_bw (psum_bw)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .din     (bus.psum_in[lane_lsb(i, psum_bw) +: psum_bw]),
            .load    (lane_load),
            .clear   (lane_clear),
            .finish  (lane_finish),
            .relu_en (relu_en),
            .dout    (bus.sfp_out[lane_lsb(i, psum_bw) +: psum_bw])
        );
    end

    // Tap counting, output hold and pixel counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ACC;
            tap_cnt     <= '0;
            out_valid_q <= 1'b0;
            pix_cnt     <= '0;
        end else begin
            case (state)
                ACC: begin
                    if (flush) begin
                        tap_cnt <= '0;
                    end else if (bus.in_valid) begin
                        if (last_tap) begin
                            tap_cnt     <= '0;
                            out_valid_q <= 1'b1;
                            state       <= HOLD;
                        end else begin
                            tap_cnt <= tap_cnt + TAP_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        pix_cnt     <= pix_cnt + PIX_W'(1);
                        state       <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_accum_sfp.sv
// Scoreboard bench: a lane-wise integer model predicts every finished pixel,
// a monitor compares them as the DUT hands them over.
module tb_psum_accum_sfp;

    localparam int PSUM_BW = 16;
    localparam int COL     = 8;
    localparam int NTAP    = 9;
    localparam int PIX_W   = 8;
    localparam int VW      = PSUM_BW * COL;
    localparam int LMAX    = 32767;
    localparam int LMIN    = -32768;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             relu_en = 1'b0;
    logic             flush = 1'b0;
    logic [PIX_W-1:0] pix_cnt;
    logic             busy;

    psum_accum_sfp_if #(.psum_bw(PSUM_BW), .col(COL)) bus ();

    psum_accum_sfp #(
        .psum_bw (PSUM_BW),
        .col     (COL),
        .NTAP    (NTAP),
        .PIX_W   (PIX_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .relu_en (relu_en),
        .flush   (flush),
        .pix_cnt (pix_cnt),
        .busy    (busy)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    int              macc [COL];
    int              mtaps;
    logic [VW-1:0]   expq [$];
    int              exp_pix;
    int              ready_mode;   // 0: always ready, 1: never ready, 2: random

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic int lane_of(input logic [VW-1:0] v, input int l);
        logic signed [PSUM_BW-1:0] x;
        x = v[l*PSUM_BW +: PSUM_BW];
        return int'(x);
    endfunction

    function automatic logic [VW-1:0] splat(input int val);
        logic [VW-1:0] v;
        for (int l = 0; l < COL; l++) v[l*PSUM_BW +: PSUM_BW] = PSUM_BW'(val);
        return v;
    endfunction

    task automatic model_clear();
        for (int l = 0; l < COL; l++) macc[l] = 0;
        mtaps = 0;
    endtask

    task automatic model_accept(input logic [VW-1:0] v, input logic relu);
        logic [VW-1:0] res;
        int s;
        for (int l = 0; l < COL; l++) begin
            s = macc[l] + lane_of(v, l);
            if (s > LMAX) s = LMAX;
            if (s < LMIN) s = LMIN;
            macc[l] = s;
        end
        mtaps++;
        if (mtaps == NTAP) begin
            for (int l = 0; l < COL; l++)
                res[l*PSUM_BW +: PSUM_BW] = (relu && macc[l] < 0) ? '0 : PSUM_BW'(macc[l]);
            expq.push_back(res);
            model_clear();
        end
    endtask

    // Out_ready driver.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'b0;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compares each output handshake against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && bus.out_valid && bus.out_ready) begin
                if (expq.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_pixel: got %h expected none", bus.sfp_out);
                end else begin
                    chk("pixel", bus.sfp_out, expq.pop_front());
                end
                chk("pix_cnt_at_handshake", VW'(pix_cnt), VW'(exp_pix % (1 << PIX_W)));
                exp_pix++;
            end
        end
    end

    // All stimulus tasks start and end at posedge+1.
    task automatic send_beat(input logic [VW-1:0] v, input logic relu);
        bit ok = 0;
        bus.psum_in  = v;
        bus.in_valid = 1'b1;
        relu_en      = relu;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1;
                break;
            end
        end
        if (ok) model_accept(v, relu);
        else begin
            n_checks++;
            $display("FAIL accept_timeout: got in_ready=0 expected in_ready=1 within 400 cycles");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int c = 0;
        while (expq.size() != 0 && c < 300) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (expq.size() != 0) begin
            n_checks++;
            $display("FAIL drain_timeout: got %0d pending expected 0", expq.size());
            expq.delete();
        end
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.psum_in  = '0;
        flush        = 1'b0;
        relu_en      = 1'b0;
        idle(2);
        expq.delete();
        model_clear();
        exp_pix = 0;
        reset   = 1'b0;
    endtask

    task automatic pixel_of(input logic [VW-1:0] v, input logic relu);
        for (int t = 0; t < NTAP; t++) send_beat(v, relu);
    endtask

    logic [VW-1:0] v, held;

    initial begin
        ready_mode = 0;
        exp_pix    = 0;
        model_clear();
        @(posedge clk);
        #1;
        do_reset();

        // Reset values.
        @(negedge clk);
        chk("rst_out_valid", VW'(bus.out_valid), VW'(0));
        chk("rst_sfp_out", bus.sfp_out, '0);
        chk("rst_pix_cnt", VW'(pix_cnt), VW'(0));
        chk("rst_in_ready", VW'(bus.in_ready), VW'(1));
        chk("rst_busy", VW'(busy), VW'(0));
        @(posedge clk);
        #1;

        // All ones: result 9 one cycle after the ninth beat.
        pixel_of(splat(1), 1'b0);
        chk("latency_out_valid", VW'(bus.out_valid), VW'(1));
        chk("latency_sfp_out", bus.sfp_out, splat(9));
        drain();
        chk("after_hs_out_valid", VW'(bus.out_valid), VW'(0));
        chk("after_hs_pix_cnt", VW'(pix_cnt), VW'(1));

        // Mixed signs with and without ReLU.
        v = '0;
        v[0 +: PSUM_BW]       = PSUM_BW'(-5);
        v[PSUM_BW +: PSUM_BW] = PSUM_BW'(3);
        pixel_of(v, 1'b1);
        drain();
        pixel_of(v, 1'b0);
        drain();

        // Saturation both ways.
        pixel_of(splat(32'h7000), 1'b0);
        drain();
        pixel_of(splat(-28672), 1'b0);
        drain();

        // Output held while consumer stalls; extra input ignored.
        ready_mode = 1;
        v = '0;
        for (int l = 0; l < COL; l++) v[l*PSUM_BW +: PSUM_BW] = PSUM_BW'(l * 100 - 300);
        pixel_of(v, 1'b0);
        held = expq[0];
        bus.psum_in  = splat(1234);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("hold_sfp_out", bus.sfp_out, held);
            chk("hold_in_ready", VW'(bus.in_ready), VW'(0));
            chk("hold_busy", VW'(busy), VW'(1));
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        ready_mode   = 0;
        drain();
        chk("hold_pix_cnt", VW'(pix_cnt), VW'(exp_pix % (1 << PIX_W)));
        pixel_of(splat(-2), 1'b1);
        drain();

        // Flush together with a fifth beat.
        for (int t = 0; t < 4; t++) send_beat(splat(7), 1'b0);
        @(negedge clk);
        chk("partial_busy", VW'(busy), VW'(1));
        @(posedge clk);
        #1;
        bus.psum_in  = splat(7);
        bus.in_valid = 1'b1;
        flush        = 1'b1;
        @(posedge clk);
        #1;
        model_clear();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_busy", VW'(busy), VW'(0));
        @(posedge clk);
        #1;
        pixel_of(splat(1), 1'b0);
        chk("flush_result", bus.sfp_out, splat(9));
        drain();

        // Reset mid-accumulation.
        for (int t = 0; t < 5; t++) send_beat(splat(int'($urandom_range(0, 500))), 1'b0);
        do_reset();
        @(negedge clk);
        chk("midrst_busy", VW'(busy), VW'(0));
        chk("midrst_pix_cnt", VW'(pix_cnt), VW'(0));
        @(posedge clk);
        #1;
        pixel_of(splat(2), 1'b0);
        chk("midrst_result", bus.sfp_out, splat(18));
        drain();

        // Reset while holding a pixel.
        ready_mode = 1;
        pixel_of(splat(3), 1'b0);
        do_reset();
        ready_mode = 0;
        @(negedge clk);
        chk("holdrst_out_valid", VW'(bus.out_valid), VW'(0));
        chk("holdrst_sfp_out", bus.sfp_out, '0);
        @(posedge clk);
        #1;

        // Random traffic over 256 pixels: pix_cnt wraps to zero.
        ready_mode = 2;
        for (int p = 0; p < 256; p++) begin
            for (int t = 0; t < NTAP; t++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                for (int l = 0; l < COL; l++) v[l*PSUM_BW +: PSUM_BW] = PSUM_BW'($urandom);
                send_beat(v, 1'($urandom_range(0, 1)));
            end
        end
        drain();
        idle(2);
        chk("wrap_pix_cnt", VW'(pix_cnt), VW'(0));
        chk("wrap_count", VW'(exp_pix), VW'(256));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
